// File: rtl/bist_pattern_generator_if.sv
// Control and stimulus bundle between a BIST sequencer (master) and the
// pattern generator (slave).
interface bist_pattern_generator_if #(
    parameter int WIDTH = 4,
    parameter int IDX_W = 5
);
    // Handshake: start is a level sampled only while the generator is idle
    // (busy=0); a run is acknowledged by busy rising with the misr_clear pulse,
    // and completion by done, which holds until the next accepted start.
    logic             start;
    logic             abort;
    logic             seed_load;
    logic [WIDTH-1:0] seed_in;
    logic [WIDTH-1:0] pattern;
    logic             pattern_valid;
    logic [IDX_W-1:0] pattern_index;
    logic             misr_clear;
    logic             misr_enable;
    logic             busy;
    logic             done;

    modport master (
        output start, abort, seed_load, seed_in,
        input  pattern, pattern_valid, pattern_index,
        input  misr_clear, misr_enable, busy, done
    );

    modport slave (
        input  start, abort, seed_load, seed_in,
        output pattern, pattern_valid, pattern_index,
        output misr_clear, misr_enable, busy, done
    );
endinterface

// File: rtl/bist_pattern_generator.sv
// Galois-LFSR BIST pattern generator sequencing the MISR clear/enable controls.
// Optional macro BIST_TPG_ALLZERO_EN appends an all-zero vector to every run.
module bist_pattern_generator #(
    parameter int               WIDTH         = 4,
    parameter logic [WIDTH-1:0] POLY          = 4'b0011,
    parameter logic [WIDTH-1:0] DEFAULT_SEED  = 4'b0001,
    parameter int               PATTERN_COUNT = 15,
    parameter int               CUT_LATENCY   = 1
) (
    input  logic                         clock,
    input  logic                         reset,
    bist_pattern_generator_if.slave      bus,
    output logic [2:0]                   state_dbg
);
    localparam int IDX_W = $clog2(PATTERN_COUNT + 2);
    localparam int FW    = (CUT_LATENCY < 2) ? 1 : $clog2(CUT_LATENCY + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PATTERN_COUNT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_RUN   = 3'd2,
        S_FLUSH = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] seed_q, seed_d;
    logic [WIDTH-1:0] lfsr_q, lfsr_d;
    logic [WIDTH-1:0] pattern_q, pattern_d;
    logic             valid_q, valid_d;
    logic [IDX_W-1:0] index_q, index_d;
    logic             clear_q, clear_d;
    logic             enable_q, enable_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [FW-1:0]    flush_cnt_q, flush_cnt_d;
    logic             finish_run, go_done;

    function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] q);
        logic [WIDTH-1:0] n;
        n[0] = q[WIDTH-1];
        for (int i = 1; i < WIDTH; i++) begin
            n[i] = q[i-1] ^ (q[WIDTH-1] & POLY[i]);
        end
        return n;
    endfunction

    always_comb begin
        state_d     = state_q;
        seed_d      = seed_q;
        lfsr_d      = lfsr_q;
        pattern_d   = pattern_q;
        valid_d     = valid_q;
        index_d     = index_q;
        clear_d     = 1'b0;
        enable_d    = enable_q;
        busy_d      = busy_q;
        done_d      = done_q;
        flush_cnt_d = flush_cnt_q;
        finish_run  = 1'b0;
        go_done     = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                // An all-zero seed would lock the LFSR, so it is replaced.
                if (bus.seed_load) begin
                    seed_d = (bus.seed_in == '0) ? DEFAULT_SEED : bus.seed_in;
                end
                if (bus.start && !bus.abort) begin
                    state_d = S_CLEAR;
                    lfsr_d  = seed_d;
                    done_d  = 1'b0;
                    clear_d = 1'b1;
                    busy_d  = 1'b1;
                    index_d = '0;
                end
            end
            S_CLEAR: begin
                state_d   = S_RUN;
                pattern_d = lfsr_q;
                lfsr_d    = lfsr_step(lfsr_q);
                valid_d   = 1'b1;
                enable_d  = 1'b1;
                index_d   = '0;
            end
            S_RUN: begin
`ifdef BIST_TPG_ALLZERO_EN
                if (index_q == IDX_W'(PATTERN_COUNT)) begin
                    finish_run = 1'b1;
                end else if (index_q == LAST_IDX) begin
                    pattern_d = '0;
                    index_d   = index_q + 1'b1;
                end else begin
                    pattern_d = lfsr_q;
                    lfsr_d    = lfsr_step(lfsr_q);
                    index_d   = index_q + 1'b1;
                end
`else
                if (index_q == LAST_IDX) begin
                    finish_run = 1'b1;
                end else begin
                    pattern_d = lfsr_q;
                    lfsr_d    = lfsr_step(lfsr_q);
                    index_d   = index_q + 1'b1;
                end
`endif
            end
            S_FLUSH: begin
                if (flush_cnt_q == '0) begin
                    go_done = 1'b1;
                end else begin
                    flush_cnt_d = flush_cnt_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (finish_run) begin
            valid_d = 1'b0;
            if (CUT_LATENCY > 0) begin
                state_d     = S_FLUSH;
                flush_cnt_d = FW'(CUT_LATENCY - 1);
            end else begin
                go_done = 1'b1;
            end
        end

        if (go_done) begin
            state_d  = S_DONE;
            valid_d  = 1'b0;
            enable_d = 1'b0;
            busy_d   = 1'b0;
            done_d   = 1'b1;
        end

        // Abort only acts on an active run and wins over everything above.
        if (bus.abort && busy_q) begin
            state_d  = S_IDLE;
            valid_d  = 1'b0;
            enable_d = 1'b0;
            clear_d  = 1'b0;
            busy_d   = 1'b0;
            done_d   = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            seed_q      <= DEFAULT_SEED;
            lfsr_q      <= DEFAULT_SEED;
            pattern_q   <= '0;
            valid_q     <= 1'b0;
            index_q     <= '0;
            clear_q     <= 1'b0;
            enable_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            seed_q      <= seed_d;
            lfsr_q      <= lfsr_d;
            pattern_q   <= pattern_d;
            valid_q     <= valid_d;
            index_q     <= index_d;
            clear_q     <= clear_d;
            enable_q    <= enable_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign bus.pattern       = pattern_q;
    assign bus.pattern_valid = valid_q;
    assign bus.pattern_index = index_q;
    assign bus.misr_clear    = clear_q;
    assign bus.misr_enable   = enable_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign state_dbg         = state_q;
endmodule

// File: doc/bist_pattern_generator.md
Name: bist_pattern_generator

Overview:
LFSR-based test pattern generator and sequencing controller for the BIST path. It produces the stimulus stream into the circuit under test and drives the clear and enable controls of the downstream MISR response analyzer. Its LFSR uses the same internal-XOR (Galois) structure and polynomial as the MISR, so signatures are reproducible from seed and count alone.

Parameters:
WIDTH, 4, pattern/LFSR width in bits
POLY, 4'b0011, Galois tap mask: bit i (i>=1) XORs q[WIDTH-1] into stage i; default is x^4+x+1
DEFAULT_SEED, 4'b0001, seed after reset, and the substitute for any all-zero seed
PATTERN_COUNT, 15, patterns issued per run; must be >=1
CUT_LATENCY, 1, flush cycles after the last pattern during which the MISR keeps capturing

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high; forces the reset state below
start  input  1  begin a run; sampled in IDLE or DONE only
abort  input  1  terminate the current run and return to IDLE
seed_load  input  1  load seed_in into the seed register; honoured in IDLE or DONE only
seed_in  input  WIDTH  seed value
pattern  output  WIDTH  registered stimulus to the CUT
pattern_valid  output  1  pattern holds a live test vector this cycle
pattern_index  output  $clog2(PATTERN_COUNT+2)  index of the current pattern, 0-based
misr_clear  output  1  one-cycle clear pulse to the MISR
misr_enable  output  1  MISR capture enable
busy  output  1  high in CLEAR, RUN and FLUSH
done  output  1  run completed normally; held high until the next start

Behaviour:
- Reset value of every output is 0. The seed register resets to DEFAULT_SEED, the LFSR to DEFAULT_SEED, and the state to IDLE.
- LFSR step: next[0]=q[W-1]; next[i]=q[i-1]^(q[W-1]&POLY[i]) for i>=1. With the defaults and seed 0001 this gives a maximal period of 15.
- States: IDLE, CLEAR, RUN, FLUSH, DONE.
- IDLE/DONE, seed handling: seed_load=1 writes seed_in to the seed register. An all-zero seed_in stores DEFAULT_SEED instead, which prevents LFSR lock-up.
- IDLE/DONE, start: start=1 loads the LFSR from the seed register, clears done and moves to CLEAR.
  - If seed_load and start are both high in the same cycle, the new seed is used for that run.
- CLEAR: exactly one cycle with misr_clear=1 and misr_enable=0, then RUN. pattern_index is 0.
- RUN: lasts PATTERN_COUNT cycles with pattern_valid=1 and misr_enable=1.
  - The first RUN cycle presents the seed.
  - The LFSR advances every cycle and pattern_index increments every cycle.
  - After index PATTERN_COUNT-1 the state moves to FLUSH, or to DONE if CUT_LATENCY=0.
- FLUSH: lasts CUT_LATENCY cycles with pattern_valid=0 and misr_enable=1. pattern holds its last value. Then DONE.
- DONE: done=1, busy=0, misr_enable=0. The state stays in DONE until start.
- Latency: start sampled at edge k gives misr_clear high in cycle k+1 and the first pattern_valid in cycle k+2.
- start while busy is ignored. seed_load while busy is ignored, and the seed register is unchanged.
- abort in any busy state: the next state is IDLE, and pattern_valid, misr_enable, misr_clear and busy drop to 0 at the next edge. done stays 0.
  - abort in IDLE/DONE has no effect.
  - abort has priority over start in the same cycle.
- PATTERN_COUNT greater than the LFSR period is legal; the sequence simply wraps and repeats.
- Asynchronous reset during a run immediately zeroes all outputs and restores the seed register to DEFAULT_SEED.

Optional Feature:
Macro: BIST_TPG_ALLZERO_EN
- Defined: RUN appends one extra cycle after index PATTERN_COUNT-1. In that cycle pattern is all-zero, pattern_valid=1 and pattern_index=PATTERN_COUNT. The run is therefore PATTERN_COUNT+1 patterns, covering the vector the LFSR cannot produce.
- Undefined: exactly PATTERN_COUNT patterns and no all-zero vector. pattern_index never reaches PATTERN_COUNT.

Test Plan:
- Reset asserted mid-RUN -> all outputs 0 asynchronously; after release, start gives a first pattern of 0001 (DEFAULT_SEED).
- Defaults, start pulse -> misr_clear for 1 cycle, then 15 valid patterns 1,2,4,8,3,6,C,B,5,A,7,E,F,D,9 (hex), 1 flush cycle with misr_enable=1 and pattern_valid=0, then done=1 held.
- seed_load with seed_in=0000, then start -> first pattern 0001. seed_load with 1011, then start -> sequence 1011,0101,1010 ...
- start and seed_load pulsed during RUN -> no restart, seed register unchanged, index sequence 0..14 uninterrupted.
- abort at pattern_index 5 -> next cycle IDLE with pattern_valid=0, busy=0, done=0. A following start replays from the seed at index 0.
- BIST_TPG_ALLZERO_EN defined -> 16 valid patterns, the last being 0000 with pattern_index=15, then FLUSH and DONE.
